// File: rtl/ex_stage.sv
// Execute stage of the RV32IM pipeline: combinational RV32I ALU/branch/jump
// logic plus an iterative 32-step multiply/divide unit that stalls the pipe.
module ex_stage #(
  parameter int AddrLen     = 32,
  parameter int RegLen      = 32,
  parameter int OpCodeLen   = 5,
  parameter int PipelineNum = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [AddrLen-1:0]     pc_i,
  input  logic [RegLen-1:0]      reg1_i,
  input  logic [RegLen-1:0]      reg2_i,
  input  logic [RegLen-1:0]      imm_i,
  input  logic [4:0]             rd_i,
  input  logic                   rd_enable_i,
  input  logic [OpCodeLen-1:0]   aluop_i,
  input  logic [PipelineNum-1:0] stall_i,
  output logic [4:0]             rd_o,
  output logic                   rd_enable_o,
  output logic [RegLen-1:0]      result_o,
  output logic                   jump_o,
  output logic [AddrLen-1:0]     jump_addr_o,
  output logic                   stall_req_o
);

  localparam int CntW = $clog2(RegLen);
  localparam int AccW = 2 * RegLen;

  localparam logic [OpCodeLen-1:0] OP_ADD    = OpCodeLen'(1);
  localparam logic [OpCodeLen-1:0] OP_SUB    = OpCodeLen'(2);
  localparam logic [OpCodeLen-1:0] OP_SLL    = OpCodeLen'(3);
  localparam logic [OpCodeLen-1:0] OP_SLT    = OpCodeLen'(4);
  localparam logic [OpCodeLen-1:0] OP_SLTU   = OpCodeLen'(5);
  localparam logic [OpCodeLen-1:0] OP_XOR    = OpCodeLen'(6);
  localparam logic [OpCodeLen-1:0] OP_SRL    = OpCodeLen'(7);
  localparam logic [OpCodeLen-1:0] OP_SRA    = OpCodeLen'(8);
  localparam logic [OpCodeLen-1:0] OP_OR     = OpCodeLen'(9);
  localparam logic [OpCodeLen-1:0] OP_AND    = OpCodeLen'(10);
  localparam logic [OpCodeLen-1:0] OP_BEQ    = OpCodeLen'(11);
  localparam logic [OpCodeLen-1:0] OP_BNE    = OpCodeLen'(12);
  localparam logic [OpCodeLen-1:0] OP_BLT    = OpCodeLen'(13);
  localparam logic [OpCodeLen-1:0] OP_BGE    = OpCodeLen'(14);
  localparam logic [OpCodeLen-1:0] OP_BLTU   = OpCodeLen'(15);
  localparam logic [OpCodeLen-1:0] OP_BGEU   = OpCodeLen'(16);
  localparam logic [OpCodeLen-1:0] OP_JAL    = OpCodeLen'(17);
  localparam logic [OpCodeLen-1:0] OP_JALR   = OpCodeLen'(18);
  localparam logic [OpCodeLen-1:0] OP_LUI    = OpCodeLen'(19);
  localparam logic [OpCodeLen-1:0] OP_AUIPC  = OpCodeLen'(20);
  localparam logic [OpCodeLen-1:0] OP_MUL    = OpCodeLen'(21);
  localparam logic [OpCodeLen-1:0] OP_MULH   = OpCodeLen'(22);
  localparam logic [OpCodeLen-1:0] OP_MULHSU = OpCodeLen'(23);
  localparam logic [OpCodeLen-1:0] OP_MULHU  = OpCodeLen'(24);
  localparam logic [OpCodeLen-1:0] OP_DIV    = OpCodeLen'(25);
  localparam logic [OpCodeLen-1:0] OP_DIVU   = OpCodeLen'(26);
  localparam logic [OpCodeLen-1:0] OP_REM    = OpCodeLen'(27);
  localparam logic [OpCodeLen-1:0] OP_REMU   = OpCodeLen'(28);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

  function automatic logic [RegLen-1:0] cond_neg(input logic [RegLen-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [AccW-1:0] cond_neg_wide(input logic [AccW-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  md_state_t            state;
  logic [CntW-1:0]      count;
  logic [OpCodeLen-1:0] op_q;
  logic                 neg_main;   // product / quotient negation
  logic                 neg_rem;    // remainder takes the dividend's sign
  logic [RegLen-1:0]    operand_b;  // |multiplicand| or |divisor|
  logic [AccW-1:0]      acc;        // product, or {remainder, quotient}

  logic signed [RegLen-1:0] op1_s, op2_s, sra_res;
  logic [RegLen-1:0]  alu_res;
  logic               alu_jump;
  logic [AddrLen-1:0] alu_addr, br_target;
  logic [RegLen-1:0]  jalr_sum;
  logic               is_md, is_div, is_mul_op;
  logic               sign_a, sign_b;
  logic [RegLen-1:0]  mag_a, mag_b;
  logic [RegLen:0]    mul_sum, div_trial;
  logic [AccW-1:0]    acc_step, prod;
  logic [RegLen-1:0]  md_res;
  logic               md_pending;
  logic               unused_stall;

  assign op1_s     = reg1_i;
  assign op2_s     = reg2_i;
  assign sra_res   = op1_s >>> reg2_i[4:0];
  assign br_target = pc_i + imm_i[AddrLen-1:0];
  assign jalr_sum  = reg1_i + imm_i;
  assign unused_stall = ^{stall_i[PipelineNum-1:4], stall_i[2:0]};

  always_comb begin
    alu_res  = '0;
    alu_jump = 1'b0;
    alu_addr = '0;
    case (aluop_i)
      OP_ADD:   alu_res = reg1_i + reg2_i;
      OP_SUB:   alu_res = reg1_i - reg2_i;
      OP_SLL:   alu_res = reg1_i << reg2_i[4:0];
      OP_SLT:   alu_res = RegLen'(op1_s < op2_s);
      OP_SLTU:  alu_res = RegLen'(reg1_i < reg2_i);
      OP_XOR:   alu_res = reg1_i ^ reg2_i;
      OP_SRL:   alu_res = reg1_i >> reg2_i[4:0];
      OP_SRA:   alu_res = sra_res;
      OP_OR:    alu_res = reg1_i | reg2_i;
      OP_AND:   alu_res = reg1_i & reg2_i;
      OP_BEQ:   alu_jump = (reg1_i == reg2_i);
      OP_BNE:   alu_jump = (reg1_i != reg2_i);
      OP_BLT:   alu_jump = (op1_s < op2_s);
      OP_BGE:   alu_jump = (op1_s >= op2_s);
      OP_BLTU:  alu_jump = (reg1_i < reg2_i);
      OP_BGEU:  alu_jump = (reg1_i >= reg2_i);
      OP_JAL: begin
        alu_jump = 1'b1;
        alu_res  = RegLen'(pc_i + AddrLen'(4));
      end
      OP_JALR: begin
        alu_jump = 1'b1;
        alu_res  = RegLen'(pc_i + AddrLen'(4));
      end
      OP_LUI:   alu_res = reg2_i;
      OP_AUIPC: alu_res = RegLen'(br_target);
      default:  alu_res = '0;
    endcase
    if (alu_jump)
      alu_addr = (aluop_i == OP_JALR) ? {jalr_sum[AddrLen-1:1], 1'b0} : br_target;
  end

  // Operand conditioning: the datapath works on magnitudes, signs fixed up in DONE
  assign is_md     = (aluop_i >= OP_MUL) && (aluop_i <= OP_REMU);
  assign is_div    = (aluop_i >= OP_DIV) && (aluop_i <= OP_REMU);
  assign is_mul_op = (op_q >= OP_MUL) && (op_q <= OP_MULHU);
  assign sign_a = reg1_i[RegLen-1] && (aluop_i == OP_MUL || aluop_i == OP_MULH ||
                  aluop_i == OP_MULHSU || aluop_i == OP_DIV || aluop_i == OP_REM);
  assign sign_b = reg2_i[RegLen-1] && (aluop_i == OP_MUL || aluop_i == OP_MULH ||
                  aluop_i == OP_DIV || aluop_i == OP_REM);
  assign mag_a  = cond_neg(reg1_i, sign_a);
  assign mag_b  = cond_neg(reg2_i, sign_b);

  // One iteration: shift-add for multiply, restoring subtract for divide
  assign mul_sum   = acc[0] ? ({1'b0, acc[AccW-1:RegLen]} + {1'b0, operand_b})
                            : {1'b0, acc[AccW-1:RegLen]};
  assign div_trial = acc[AccW-1:RegLen-1] - {1'b0, operand_b};

  always_comb begin
    if (is_mul_op)
      acc_step = {mul_sum, acc[RegLen-1:1]};
    else if (!div_trial[RegLen])
      acc_step = {div_trial[RegLen-1:0], acc[RegLen-2:0], 1'b1};
    else
      acc_step = {acc[AccW-2:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      op_q      <= '0;
      neg_main  <= 1'b0;
      neg_rem   <= 1'b0;
      operand_b <= '0;
      acc       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_md) begin
            op_q      <= aluop_i;
            operand_b <= mag_b;
            count     <= '0;
            if (is_div && reg2_i == '0) begin
              // Divide by zero: all-ones quotient, remainder restored to the dividend
              acc      <= {mag_a, {RegLen{1'b1}}};
              neg_main <= 1'b0;
              neg_rem  <= sign_a;
              state    <= DONE;
            end else begin
              acc      <= {{RegLen{1'b0}}, mag_a};
              neg_main <= sign_a ^ sign_b;
              neg_rem  <= sign_a;
              state    <= BUSY;
            end
          end
        end
        BUSY: begin
          acc   <= acc_step;
          count <= count + CntW'(1);
          if (count == CntW'(RegLen - 1))
            state <= DONE;
        end
        DONE: begin
          if (!stall_i[3])
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign prod = cond_neg_wide(acc, neg_main);

  always_comb begin
    case (op_q)
      OP_MUL:                      md_res = prod[RegLen-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: md_res = prod[AccW-1:RegLen];
      OP_DIV, OP_DIVU:             md_res = cond_neg(acc[RegLen-1:0], neg_main);
      default:                     md_res = cond_neg(acc[AccW-1:RegLen], neg_rem);
    endcase
  end

  assign md_pending  = (state == BUSY) || (state == IDLE && is_md);
  assign stall_req_o = !rst && md_pending;
  assign rd_o        = rst ? 5'd0 : rd_i;
  assign rd_enable_o = !rst && rd_enable_i && !md_pending;
  assign result_o    = rst ? '0 : ((state == DONE) ? md_res : alu_res);
  assign jump_o      = !rst && alu_jump;
  assign jump_addr_o = rst ? '0 : alu_addr;

endmodule
